// File: rtl/ahb_slave_port_mux_if.sv
// ahb_slave_port_mux_if: bundles the per-master request side, the slave response side
// and the mux status outputs of one AHB slave port.
`default_nettype none

interface ahb_slave_port_mux_if #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0][1:0]            i_htrans;
    logic [NUM_MASTERS-1:0]                 i_hwrite;
    logic [NUM_MASTERS-1:0][2:0]            i_hsize;
    logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] i_haddr;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] i_hwdata;
    logic [NUM_MASTERS-1:0]                 i_hselx;
    logic [NUM_MASTERS-1:0]                 bus_grant;
    logic                                   i_s_hreadyout;
    logic                                   i_s_hresp;
    logic [DATA_WIDTH-1:0]                  i_s_hrdata;

    logic [1:0]                             o_htrans;
    logic                                   o_hwrite;
    logic [2:0]                             o_hsize;
    logic [ADDR_WIDTH-1:0]                  o_haddr;
    logic [DATA_WIDTH-1:0]                  o_hwdata;
    logic                                   o_hselx;
    logic                                   o_hready;
    logic [NUM_MASTERS-1:0]                 o_m_hready;
    logic [NUM_MASTERS-1:0]                 o_m_hresp;
    logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] o_m_hrdata;
    logic                                   o_grant_err;
    logic [NUM_MASTERS-1:0][15:0]           o_xfer_cnt;

    // Mux-side view: consumes masters/slave/arbiter, drives the slave bus and responses.
    modport slave (
        input  i_htrans, i_hwrite, i_hsize, i_haddr, i_hwdata, i_hselx, bus_grant,
        input  i_s_hreadyout, i_s_hresp, i_s_hrdata,
        output o_htrans, o_hwrite, o_hsize, o_haddr, o_hwdata, o_hselx, o_hready,
        output o_m_hready, o_m_hresp, o_m_hrdata, o_grant_err, o_xfer_cnt
    );

    modport master (
        output i_htrans, i_hwrite, i_hsize, i_haddr, i_hwdata, i_hselx, bus_grant,
        output i_s_hreadyout, i_s_hresp, i_s_hrdata,
        input  o_htrans, o_hwrite, o_hsize, o_haddr, o_hwdata, o_hselx, o_hready,
        input  o_m_hready, o_m_hresp, o_m_hrdata, o_grant_err, o_xfer_cnt
    );
endinterface

`default_nettype wire

// File: rtl/ahb_slave_port_mux.sv
// ahb_slave_port_mux: routes granted master address/data phases onto one AHB slave port.
// Optional macro SLAVE_MUX_XFER_CNT_EN enables per-master saturating transfer counters.
`default_nettype none

module ahb_slave_port_mux #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    ahb_slave_port_mux_if.slave bus
);
    localparam int OWN_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t           r_state;
    logic [OWN_W-1:0] r_data_owner;
    logic             r_grant_err;
    logic [OWN_W-1:0] w_addr_owner;
    logic             w_addr_any;
    logic             w_multi_grant;
    logic             w_accept;

    // Descending scan so the lowest granted index wins.
    always_comb begin
        w_addr_owner = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (bus.bus_grant[i]) w_addr_owner = OWN_W'(i);
        end
    end

    assign w_addr_any    = |bus.bus_grant;
    assign w_multi_grant = (bus.bus_grant & (bus.bus_grant - NUM_MASTERS'(1))) != '0;

    always_comb begin
        bus.o_htrans = 2'b00;
        bus.o_hwrite = 1'b0;
        bus.o_hsize  = 3'b000;
        bus.o_haddr  = '0;
        bus.o_hselx  = 1'b0;
        if (w_addr_any) begin
            bus.o_htrans = bus.i_htrans[w_addr_owner];
            bus.o_hwrite = bus.i_hwrite[w_addr_owner];
            bus.o_hsize  = bus.i_hsize[w_addr_owner];
            bus.o_haddr  = bus.i_haddr[w_addr_owner];
            bus.o_hselx  = bus.i_hselx[w_addr_owner];
        end
    end

    assign bus.o_hready    = bus.i_s_hreadyout;
    assign bus.o_grant_err = r_grant_err;
    assign w_accept = bus.i_s_hreadyout & w_addr_any & bus.o_hselx & bus.o_htrans[1];

    always_comb begin
        bus.o_hwdata   = '0;
        bus.o_m_hready = '1;
        bus.o_m_hresp  = '0;
        bus.o_m_hrdata = '0;
        if (r_state == ST_DATA) begin
            bus.o_hwdata                 = bus.i_hwdata[r_data_owner];
            bus.o_m_hready[r_data_owner] = bus.i_s_hreadyout;
            bus.o_m_hresp[r_data_owner]  = bus.i_s_hresp;
            bus.o_m_hrdata[r_data_owner] = bus.i_s_hrdata;
        end
    end

    // Everything but the sticky error freezes while the slave inserts wait states.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_data_owner <= '0;
            r_grant_err  <= 1'b0;
        end else begin
            if (w_multi_grant) r_grant_err <= 1'b1;
            if (bus.i_s_hreadyout) begin
                if (w_accept) begin
                    r_state      <= ST_DATA;
                    r_data_owner <= w_addr_owner;
                end else begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

`ifdef SLAVE_MUX_XFER_CNT_EN
    logic [NUM_MASTERS-1:0][15:0] r_xfer_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_xfer_cnt <= '0;
        end else if (r_state == ST_DATA && bus.i_s_hreadyout && !bus.i_s_hresp &&
                     r_xfer_cnt[r_data_owner] != 16'hFFFF) begin
            r_xfer_cnt[r_data_owner] <= r_xfer_cnt[r_data_owner] + 16'd1;
        end
    end

    assign bus.o_xfer_cnt = r_xfer_cnt;
`else
    assign bus.o_xfer_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave_port_mux.sv
// tb_ahb_slave_port_mux: directed checks of routing, wait states, errors, grant errors,
// reset and transfer counting for ahb_slave_port_mux (2 masters, 32-bit).
`default_nettype none

module tb_ahb_slave_port_mux;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ahb_slave_port_mux_if #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    ahb_slave_port_mux #(.NUM_MASTERS(2), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_htrans      = '0;
        bus.i_hwrite      = '0;
        bus.i_hsize       = '0;
        bus.i_haddr       = '0;
        bus.i_hwdata      = '0;
        bus.i_hselx       = '0;
        bus.bus_grant     = '0;
        bus.i_s_hreadyout = 1'b1;
        bus.i_s_hresp     = 1'b0;
        bus.i_s_hrdata    = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (bus.o_grant_err !== 1'b0 || bus.o_htrans !== 2'b00 || bus.o_hselx !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl: err=%b htrans=%b hselx=%b required 0/00/0",
                     bus.o_grant_err, bus.o_htrans, bus.o_hselx);
        end
        n_checks++;
        if (bus.o_hwdata !== 32'h0 || bus.o_m_hready !== 2'b11 || bus.o_m_hresp !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_data: hwdata=%h m_hready=%b m_hresp=%b required 0/11/00",
                     bus.o_hwdata, bus.o_m_hready, bus.o_m_hresp);
        end
        n_checks++;
        if (bus.o_xfer_cnt !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: xfer_cnt=%h required 0", bus.o_xfer_cnt);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_write();
        bus.bus_grant   = 2'b10;
        bus.i_htrans[1] = 2'b10;
        bus.i_hwrite[1] = 1'b1;
        bus.i_hsize[1]  = 3'b010;
        bus.i_haddr[1]  = 32'h0000_1000;
        bus.i_hselx[1]  = 1'b1;
        bus.i_haddr[0]  = 32'h0000_0BAD;
        @(negedge clk);
        n_checks++;
        if (bus.o_haddr !== 32'h0000_1000 || bus.o_htrans !== 2'b10 || bus.o_hwrite !== 1'b1 ||
            bus.o_hsize !== 3'b010 || bus.o_hselx !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_addr: haddr=%h htrans=%b hwrite=%b hsize=%b required 00001000/10/1/010",
                     bus.o_haddr, bus.o_htrans, bus.o_hwrite, bus.o_hsize);
        end
        step();
        bus.bus_grant   = 2'b00;
        bus.i_htrans    = '0;
        bus.i_hselx     = '0;
        bus.i_hwdata[1] = 32'hA5A5_0001;
        bus.i_hwdata[0] = 32'h1111_1111;
        bus.i_s_hrdata  = 32'hCAFE_0000;
        @(negedge clk);
        n_checks++;
        if (bus.o_hwdata !== 32'hA5A5_0001 || bus.o_m_hready !== 2'b11 || bus.o_htrans !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_data: hwdata=%h m_hready=%b htrans=%b required a5a50001/11/00",
                     bus.o_hwdata, bus.o_m_hready, bus.o_htrans);
        end
        n_checks++;
        if (bus.o_m_hrdata[1] !== 32'hCAFE_0000 || bus.o_m_hrdata[0] !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_rdata: m1=%h m0=%h required cafe0000/0",
                     bus.o_m_hrdata[1], bus.o_m_hrdata[0]);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (bus.o_hwdata !== 32'h0 || bus.o_m_hrdata[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL basic_idle: hwdata=%h m1_rdata=%h required 0/0",
                     bus.o_hwdata, bus.o_m_hrdata[1]);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_wait_states();
        bus.bus_grant   = 2'b01;
        bus.i_htrans[0] = 2'b10;
        bus.i_hwrite[0] = 1'b1;
        bus.i_haddr[0]  = 32'h0000_2000;
        bus.i_hselx[0]  = 1'b1;
        step();
        bus.i_s_hreadyout = 1'b0;
        bus.i_hwdata[0]   = 32'h0000_D000;
        bus.i_hwdata[1]   = 32'h0000_D111;
        bus.bus_grant     = 2'b10;
        bus.i_htrans      = {2'b10, 2'b00};
        bus.i_hselx       = 2'b10;
        bus.i_haddr[1]    = 32'h0000_3000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.o_hwdata !== 32'h0000_D000 || bus.o_m_hready !== 2'b10 || bus.o_hready !== 1'b0) begin
                n_fail++;
                $display("FAIL wait_hold[%0d]: hwdata=%h m_hready=%b hready=%b required 0000d000/10/0",
                         c, bus.o_hwdata, bus.o_m_hready, bus.o_hready);
            end
            step();
        end
        bus.i_s_hreadyout = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.o_hwdata !== 32'h0000_D000 || bus.o_m_hready !== 2'b11 || bus.o_haddr !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL wait_release: hwdata=%h m_hready=%b haddr=%h required 0000d000/11/00003000",
                     bus.o_hwdata, bus.o_m_hready, bus.o_haddr);
        end
        step();
        bus.bus_grant = 2'b00;
        bus.i_htrans  = '0;
        @(negedge clk);
        n_checks++;
        if (bus.o_hwdata !== 32'h0000_D111) begin
            n_fail++;
            $display("FAIL wait_next_owner: hwdata=%h required 0000d111", bus.o_hwdata);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_error_response();
        bus.bus_grant   = 2'b10;
        bus.i_htrans[1] = 2'b10;
        bus.i_hwrite[1] = 1'b0;
        bus.i_haddr[1]  = 32'h0000_4000;
        bus.i_hselx[1]  = 1'b1;
        step();
        bus.bus_grant     = 2'b00;
        bus.i_htrans      = '0;
        bus.i_s_hresp     = 1'b1;
        bus.i_s_hreadyout = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.o_m_hresp !== 2'b10 || bus.o_m_hready !== 2'b01) begin
            n_fail++;
            $display("FAIL err_cycle1: m_hresp=%b m_hready=%b required 10/01",
                     bus.o_m_hresp, bus.o_m_hready);
        end
        step();
        bus.i_s_hreadyout = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.o_m_hresp !== 2'b10 || bus.o_m_hready !== 2'b11) begin
            n_fail++;
            $display("FAIL err_cycle2: m_hresp=%b m_hready=%b required 10/11",
                     bus.o_m_hresp, bus.o_m_hready);
        end
        step();
        bus.i_s_hresp = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.o_m_hresp !== 2'b00 || bus.o_grant_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_after: m_hresp=%b grant_err=%b required 00/0",
                     bus.o_m_hresp, bus.o_grant_err);
        end
        idle_inputs();
    endtask

    task automatic test_grant_err();
        bus.bus_grant  = 2'b11;
        bus.i_htrans   = {2'b10, 2'b10};
        bus.i_hselx    = 2'b11;
        bus.i_haddr[0] = 32'h0000_5000;
        bus.i_haddr[1] = 32'h0000_6000;
        @(negedge clk);
        n_checks++;
        if (bus.o_haddr !== 32'h0000_5000) begin
            n_fail++;
            $display("FAIL gerr_owner: haddr=%h required 00005000", bus.o_haddr);
        end
        step();
        bus.bus_grant   = 2'b00;
        bus.i_htrans    = '0;
        bus.i_hwdata[0] = 32'h0000_E000;
        bus.i_hwdata[1] = 32'h0000_E111;
        @(negedge clk);
        n_checks++;
        if (bus.o_grant_err !== 1'b1 || bus.o_hwdata !== 32'h0000_E000) begin
            n_fail++;
            $display("FAIL gerr_set: grant_err=%b hwdata=%h required 1/0000e000",
                     bus.o_grant_err, bus.o_hwdata);
        end
        step();
        step();
        @(negedge clk);
        n_checks++;
        if (bus.o_grant_err !== 1'b1) begin
            n_fail++;
            $display("FAIL gerr_sticky: grant_err=%b required 1", bus.o_grant_err);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_transfer();
        bus.bus_grant   = 2'b01;
        bus.i_htrans[0] = 2'b10;
        bus.i_hselx[0]  = 1'b1;
        step();
        bus.bus_grant     = 2'b00;
        bus.i_htrans      = '0;
        bus.i_s_hreadyout = 1'b0;
        bus.i_hwdata[0]   = 32'h0000_F000;
        @(negedge clk);
        n_checks++;
        if (bus.o_m_hready !== 2'b10 || bus.o_hwdata !== 32'h0000_F000) begin
            n_fail++;
            $display("FAIL rst_pre: m_hready=%b hwdata=%h required 10/0000f000",
                     bus.o_m_hready, bus.o_hwdata);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.o_m_hready !== 2'b11 || bus.o_hwdata !== 32'h0 || bus.o_grant_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: m_hready=%b hwdata=%h grant_err=%b required 11/0/0",
                     bus.o_m_hready, bus.o_hwdata, bus.o_grant_err);
        end
        step();
        rst_n = 1'b1;
        bus.i_s_hreadyout = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.o_m_hready !== 2'b11 || bus.o_hwdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_release: m_hready=%b hwdata=%h required 11/0",
                     bus.o_m_hready, bus.o_hwdata);
        end
        step();
        idle_inputs();
    endtask

    task automatic test_xfer_count();
        logic [15:0] exp_cnt;
        bus.bus_grant   = 2'b01;
        bus.i_htrans[0] = 2'b10;
        bus.i_hselx[0]  = 1'b1;
        for (int k = 0; k < 5; k++) step();
        bus.bus_grant = 2'b00;
        bus.i_htrans  = '0;
        step();
        bus.bus_grant   = 2'b01;
        bus.i_htrans[0] = 2'b10;
        step();
        bus.bus_grant     = 2'b00;
        bus.i_htrans      = '0;
        bus.i_s_hresp     = 1'b1;
        bus.i_s_hreadyout = 1'b0;
        step();
        bus.i_s_hreadyout = 1'b1;
        step();
        bus.i_s_hresp = 1'b0;
`ifdef SLAVE_MUX_XFER_CNT_EN
        exp_cnt = 16'd5;
`else
        exp_cnt = 16'd0;
`endif
        @(negedge clk);
        n_checks++;
        if (bus.o_xfer_cnt[0] !== exp_cnt || bus.o_xfer_cnt[1] !== 16'd0) begin
            n_fail++;
            $display("FAIL cnt_five: cnt0=%h cnt1=%h required %h/0000",
                     bus.o_xfer_cnt[0], bus.o_xfer_cnt[1], exp_cnt);
        end
`ifdef SLAVE_MUX_XFER_CNT_EN
        bus.bus_grant   = 2'b01;
        bus.i_htrans[0] = 2'b10;
        for (int k = 0; k < 65536; k++) step();
        bus.bus_grant = 2'b00;
        bus.i_htrans  = '0;
        step();
        step();
        @(negedge clk);
        n_checks++;
        if (bus.o_xfer_cnt[0] !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_saturate: cnt0=%h required ffff", bus.o_xfer_cnt[0]);
        end
`endif
        idle_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        test_reset();
        test_basic_write();
        test_wait_states();
        test_error_response();
        test_grant_err();
        test_reset_mid_transfer();
        test_xfer_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
